// File: rtl/vram_scanout.sv
// Display-side video RAM reader: raster timing, read addressing, and unpacking of
// 16-bit words into four 4-bit palette indices (MSB nibble first), 2-clock latency.
module vram_scanout #(
  parameter int   H_ACTIVE = 32,
  parameter int   H_FP     = 4,
  parameter int   H_SYNC   = 8,
  parameter int   H_BP     = 4,
  parameter int   V_ACTIVE = 32,
  parameter int   V_FP     = 2,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 2,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic [7:0]  i_base,
  output logic [7:0]  o_ram_addr,
  output logic        o_ram_re,
  input  logic [15:0] i_ram_data,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic [3:0]  o_pixel,
  output logic        o_vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int WPL     = H_ACTIVE / 4;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [7:0]    base_q, base_d;
  logic [7:0]    addr_q, addr_d;
  logic          re_q, re_d;
  logic          en_q;
  logic          active_s, hs_s, vs_s, fetch_s, vbs_s, en_rise_s, frame_end_s;
  logic [7:0]    base_sel_s;
  logic          act1_q, hs1_q, vs1_q, fetch1_q, vbs1_q;
  logic          de_q, hsync_q, vsync_q, vblank_q;
  logic [3:0]    pixel_q;
  logic [15:0]   shift_q;

  // Stage-0 decode of the raster position.
  always_comb begin
    active_s    = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
    hs_s        = (int'(h_q) >= H_ACTIVE + H_FP) && (int'(h_q) < H_ACTIVE + H_FP + H_SYNC);
    vs_s        = (int'(v_q) >= V_ACTIVE + V_FP) && (int'(v_q) < V_ACTIVE + V_FP + V_SYNC);
    fetch_s     = active_s && (h_q[1:0] == 2'b00);
    vbs_s       = (h_q == HW'(0)) && (int'(v_q) == V_ACTIVE);
    en_rise_s   = i_en && !en_q;
    frame_end_s = (int'(h_q) == H_TOTAL - 1) && (int'(v_q) == V_TOTAL - 1);
    // The first fetch after enable must already see the freshly sampled base.
    base_sel_s  = en_rise_s ? i_base : base_q;
  end

  // Next-state for counters, frame base and read address.
  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    base_d = base_q;
    addr_d = addr_q;
    re_d   = 1'b0;
    if (!i_en) begin
      h_d    = HW'(0);
      v_d    = VW'(0);
      addr_d = 8'h00;
    end else begin
      if (frame_end_s || en_rise_s) begin
        base_d = i_base;
      end else begin
        base_d = base_q;
      end
      if (fetch_s) begin
        addr_d = base_sel_s + 8'(int'(v_q) * WPL) + 8'(int'(h_q) >> 2);
        re_d   = 1'b1;
      end else begin
        addr_d = addr_q;
        re_d   = 1'b0;
      end
      if (int'(h_q) == H_TOTAL - 1) begin
        h_d = HW'(0);
        if (int'(v_q) == V_TOTAL - 1) begin
          v_d = VW'(0);
        end else begin
          v_d = v_q + VW'(1);
        end
      end else begin
        h_d = h_q + HW'(1);
        v_d = v_q;
      end
    end
  end

  // Counter, address and pixel pipeline registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_q      <= HW'(0);
      v_q      <= VW'(0);
      base_q   <= 8'h00;
      addr_q   <= 8'h00;
      re_q     <= 1'b0;
      en_q     <= 1'b0;
      act1_q   <= 1'b0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      fetch1_q <= 1'b0;
      vbs1_q   <= 1'b0;
      de_q     <= 1'b0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      vblank_q <= 1'b0;
      pixel_q  <= 4'h0;
      shift_q  <= 16'h0000;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      base_q <= base_d;
      addr_q <= addr_d;
      re_q   <= re_d;
      en_q   <= i_en;
      if (!i_en) begin
        act1_q   <= 1'b0;
        hs1_q    <= 1'b0;
        vs1_q    <= 1'b0;
        fetch1_q <= 1'b0;
        vbs1_q   <= 1'b0;
        de_q     <= 1'b0;
        hsync_q  <= ~SYNC_POL;
        vsync_q  <= ~SYNC_POL;
        vblank_q <= 1'b0;
        pixel_q  <= 4'h0;
        shift_q  <= 16'h0000;
      end else begin
        act1_q   <= active_s;
        hs1_q    <= hs_s;
        vs1_q    <= vs_s;
        fetch1_q <= fetch_s;
        vbs1_q   <= vbs_s;
        de_q     <= act1_q;
        hsync_q  <= hs1_q ? SYNC_POL : ~SYNC_POL;
        vsync_q  <= vs1_q ? SYNC_POL : ~SYNC_POL;
        vblank_q <= vbs1_q;
        // RAM data for a fetch arrives as the fetch reaches stage 1.
        if (fetch1_q) begin
          pixel_q <= i_ram_data[15:12];
          shift_q <= {i_ram_data[11:0], 4'h0};
        end else if (act1_q) begin
          pixel_q <= shift_q[15:12];
          shift_q <= {shift_q[11:0], 4'h0};
        end else begin
          pixel_q <= 4'h0;
          shift_q <= shift_q;
        end
      end
    end
  end

  assign o_ram_addr = addr_q;
  assign o_ram_re   = re_q;
  assign o_hsync    = hsync_q;
  assign o_vsync    = vsync_q;
  assign o_de       = de_q;
  assign o_pixel    = pixel_q;
  assign o_vblank   = vblank_q;

endmodule
